// File: rtl/btn_word_serializer.sv
// Sends a DATA_LEN-bit word MSB first as one-cycle o_bit0/o_bit1 strobes, then one o_commit strobe.
// Latency: first strobe one edge after accept; strobe k after edge 1+k*(GAP_CYCLES+1); commit follows the last gap.
// Backpressure: o_ready is high only in IDLE; i_valid is ignored while a word is in flight; i_abort drops the word.
module btn_word_serializer #(
  parameter int DATA_LEN   = 48,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          ck_rstn,
  input  logic [DATA_LEN-1:0]           i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_abort,
  output logic                          o_bit0,
  output logic                          o_bit1,
  output logic                          o_commit,
  output logic                          o_busy,
  output logic [$clog2(DATA_LEN+1)-1:0] o_bit_cnt
);

  localparam int CW = $clog2(DATA_LEN + 1);
  // Gap counter runs 0..GAP_CYCLES-1; keep at least one bit so GAP_CYCLES=0 still elaborates.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT,
    S_GAP,
    S_COMMIT
  } state_t;

  state_t              r_state;
  logic [DATA_LEN-1:0] r_shift;
  logic [CW-1:0]       r_cnt;
  logic [GW-1:0]       r_gap;
  logic                r_ready;
  logic                r_bit0;
  logic                r_bit1;
  logic                r_commit;
  logic                r_busy;

  logic                w_msb;
  logic                w_gap_done;

  assign w_msb      = r_shift[DATA_LEN-1];
  assign w_gap_done = (int'(r_gap) >= GAP_CYCLES - 1);

  // Single FSM: every output is a register updated on the same edge as the state.
  // COMMIT spans two edges: the first raises o_commit, the second drops it and returns to IDLE.
  always_ff @(posedge clk) begin
    if (!ck_rstn) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_ready  <= 1'b0;
      r_bit0   <= 1'b0;
      r_bit1   <= 1'b0;
      r_commit <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_bit0   <= 1'b0;
      r_bit1   <= 1'b0;
      r_commit <= 1'b0;
      if (r_state == S_IDLE) begin
        r_ready <= 1'b1;
        if (i_valid && r_ready) begin
          r_shift <= i_data;
          r_cnt   <= CW'(DATA_LEN);
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= S_BIT;
        end
      end else if (i_abort) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_ready <= 1'b1;
      end else begin
        case (r_state)
          S_BIT: begin
            r_bit1  <= w_msb;
            r_bit0  <= ~w_msb;
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt - 1'b1;
            r_gap   <= '0;
            if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
            end else if (r_cnt > CW'(1)) begin
              r_state <= S_BIT;
            end else begin
              r_state <= S_COMMIT;
            end
          end
          S_GAP: begin
            if (w_gap_done) begin
              r_state <= (r_cnt != '0) ? S_BIT : S_COMMIT;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
          S_COMMIT: begin
            if (!r_commit) begin
              r_commit <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_ready   = r_ready;
  assign o_bit0    = r_bit0;
  assign o_bit1    = r_bit1;
  assign o_commit  = r_commit;
  assign o_busy    = r_busy;
  assign o_bit_cnt = r_cnt;

endmodule

// File: tb/tb_btn_word_serializer.sv
// Bench for btn_word_serializer: instance 0 with a one-cycle gap, instance 1 with no gap.
// A slot-arithmetic reference model predicts every output each cycle; a loopback receiver rebuilds words.
// Table vectors, hand sequences (reset, mid-word reset, held i_valid) and random words with aborts.
module tb_btn_word_serializer;

  localparam int N = 48;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  t_data [2];
  logic          t_valid [2];
  logic          t_abort [2];
  logic          o_rdy [2];
  logic          o_b0 [2];
  logic          o_b1 [2];
  logic          o_cm [2];
  logic          o_bz [2];
  logic [5:0]    o_cnt [2];

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  btn_word_serializer #(.DATA_LEN(N), .GAP_CYCLES(1)) u_g1 (
    .clk(clk), .ck_rstn(rstn), .i_data(t_data[0]), .i_valid(t_valid[0]), .o_ready(o_rdy[0]),
    .i_abort(t_abort[0]), .o_bit0(o_b0[0]), .o_bit1(o_b1[0]), .o_commit(o_cm[0]),
    .o_busy(o_bz[0]), .o_bit_cnt(o_cnt[0]));

  btn_word_serializer #(.DATA_LEN(N), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .ck_rstn(rstn), .i_data(t_data[1]), .i_valid(t_valid[1]), .o_ready(o_rdy[1]),
    .i_abort(t_abort[1]), .o_bit0(o_b0[1]), .o_bit1(o_b1[1]), .o_commit(o_cm[1]),
    .o_busy(o_bz[1]), .o_bit_cnt(o_cnt[1]));

  function automatic int gap_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a word is just "cycles since accept" (j) mapped onto slots of G+1 cycles.
  bit           m_act [2];
  bit           m_rdy [2];
  int           m_j   [2];
  logic [N-1:0] m_dat [2];
  int           acc_cyc [2];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        m_act[i] = 1'b0;
        m_rdy[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (t_valid[i] && m_rdy[i]) begin
          m_act[i]   = 1'b1;
          m_j[i]     = 0;
          m_dat[i]   = t_data[i];
          m_rdy[i]   = 1'b0;
          acc_cyc[i] = cyc;
        end else begin
          m_rdy[i] = 1'b1;
        end
      end else if (t_abort[i]) begin
        m_act[i] = 1'b0;
        m_rdy[i] = 1'b1;
      end else begin
        m_j[i]++;
        if (m_j[i] == N * (gap_of(i) + 1) + 2) begin
          m_act[i] = 1'b0;
          m_rdy[i] = 1'b1;
        end
      end
    end
  end

  // Loopback receiver state plus observed event cycles.
  logic [N-1:0] rx_sh [2];
  int           rx_n  [2];
  logic [N-1:0] rx_word [2];
  int           rx_bits [2];
  int           commits [2];
  int           cm_cyc  [2];
  int           rdy_cyc [2];
  int           first_cyc [2];
  logic         prev_rdy [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rx_sh[i] = '0; rx_n[i] = 0; rx_word[i] = '0; rx_bits[i] = 0; commits[i] = 0;
      cm_cyc[i] = 0; rdy_cyc[i] = 0; first_cyc[i] = 0; prev_rdy[i] = 1'b0;
      m_act[i] = 1'b0; m_rdy[i] = 1'b0; m_j[i] = 0; m_dat[i] = '0; acc_cyc[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (chk_en) begin
        int g, slot, ph;
        logic [10:0] exp_v, act_v;
        logic e_rdy, e_bz, e_b0, e_b1, e_cm;
        logic [5:0] e_cnt;
        g = gap_of(i);
        e_rdy = m_rdy[i]; e_bz = 1'b0; e_b0 = 1'b0; e_b1 = 1'b0; e_cm = 1'b0; e_cnt = 6'd0;
        if (m_act[i]) begin
          e_bz = 1'b1;
          if (m_j[i] == 0) begin
            e_cnt = 6'(N);
          end else begin
            slot = (m_j[i] - 1) / (g + 1);
            ph   = (m_j[i] - 1) % (g + 1);
            if (slot < N) begin
              e_cnt = 6'(N - 1 - slot);
              if (ph == 0) begin
                e_b1 = m_dat[i][N-1-slot];
                e_b0 = ~m_dat[i][N-1-slot];
              end
            end else begin
              e_cm = (ph == 0);
            end
          end
        end
        exp_v = {e_rdy, e_bz, e_b0, e_b1, e_cm, e_cnt};
        act_v = {o_rdy[i], o_bz[i], o_b0[i], o_b1[i], o_cm[i], o_cnt[i]};
        chk($sformatf("model_outs_inst%0d {rdy,busy,b0,b1,commit,cnt}", i), act_v, exp_v);
        chk($sformatf("excl_inst%0d", i), {o_b0[i] & o_b1[i], (o_b0[i] | o_b1[i]) & o_cm[i]}, 0);
      end
      if (o_b0[i] || o_b1[i]) begin
        if (rx_n[i] == 0) first_cyc[i] = cyc;
        rx_sh[i] = {rx_sh[i][N-2:0], o_b1[i]};
        rx_n[i]++;
      end
      if (o_cm[i]) begin
        rx_word[i] = rx_sh[i];
        rx_bits[i] = rx_n[i];
        commits[i]++;
        cm_cyc[i]  = cyc;
      end
      if (!o_bz[i]) begin
        rx_sh[i] = '0;
        rx_n[i]  = 0;
      end
      if (o_rdy[i] && !prev_rdy[i]) rdy_cyc[i] = cyc;
      prev_rdy[i] = o_rdy[i];
    end
  end

  task automatic wait_ready(int i);
    for (int k = 0; k < 300; k++) begin
      if (o_rdy[i]) return;
      @(negedge clk); #1;
    end
    chk($sformatf("ready_timeout_inst%0d", i), o_rdy[i], 1);
  endtask

  // Hands one word over; abort_at>0 raises i_abort while the abort_at-th strobe is visible.
  task automatic send(int i, logic [N-1:0] d, int abort_at);
    int seen;
    wait_ready(i);
    t_data[i] = d;
    t_valid[i] = 1'b1;
    @(posedge clk); #1;
    t_valid[i] = 1'b0;
    if (abort_at > 0) begin
      seen = 0;
      for (int k = 0; k < 200 && seen < abort_at; k++) begin
        @(negedge clk); #1;
        if (o_b0[i] || o_b1[i]) seen++;
      end
      t_abort[i] = 1'b1;
      @(posedge clk); #1;
      t_abort[i] = 1'b0;
    end
    wait_ready(i);
    @(negedge clk); #1;
  endtask

  typedef struct {
    int           inst;
    logic [N-1:0] dat;
    int           abort_at;
    int           exp_commits;
    logic [N-1:0] exp_word;
    int           exp_cm_lat;
    int           exp_rdy_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int base;
    int f0;
    logic [63:0] r64;
    for (int i = 0; i < 2; i++) begin
      t_data[i] = '0; t_valid[i] = 1'b0; t_abort[i] = 1'b0;
    end

    vecs[0] = '{0, 48'hFF_FF_FF_FF_FF_00, 0,  1, 48'hFF_FF_FF_FF_FF_00, 97, 98};
    vecs[1] = '{1, 48'hA5A5_0000_FFFF,    0,  1, 48'hA5A5_0000_FFFF,    49, 50};
    vecs[2] = '{0, 48'h1234_5678_9ABC,    10, 0, 48'h0,                 0,  0};
    vecs[3] = '{0, 48'h0000_0000_0001,    0,  1, 48'h0000_0000_0001,    97, 98};
    vecs[4] = '{1, 48'h8000_0000_0001,    0,  1, 48'h8000_0000_0001,    49, 50};
    vecs[5] = '{1, 48'hDEAD_BEEF_CAFE,    1,  0, 48'h0,                 0,  0};

    // Reset held five cycles: every output low.
    @(posedge clk); #1;
    chk_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        chk($sformatf("reset_outs_inst%0d", i),
            {o_rdy[i], o_bz[i], o_b0[i], o_b1[i], o_cm[i], o_cnt[i]}, 0);
    end
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready_after_reset_inst%0d", i), o_rdy[i], 1);
      chk($sformatf("no_strobe_after_reset_inst%0d", i), {o_b0[i], o_b1[i], o_cm[i]}, 0);
    end

    // Table vectors.
    for (int v = 0; v < 6; v++) begin
      int i;
      i = vecs[v].inst;
      base = commits[i];
      send(i, vecs[v].dat, vecs[v].abort_at);
      chk($sformatf("vec%0d_commits", v), commits[i] - base, vecs[v].exp_commits);
      if (vecs[v].exp_commits > 0) begin
        chk($sformatf("vec%0d_word", v), rx_word[i], vecs[v].exp_word);
        chk($sformatf("vec%0d_bits", v), rx_bits[i], N);
        chk($sformatf("vec%0d_commit_lat", v), cm_cyc[i] - acc_cyc[i], vecs[v].exp_cm_lat);
        chk($sformatf("vec%0d_ready_lat", v), rdy_cyc[i] - acc_cyc[i], vecs[v].exp_rdy_lat);
      end else begin
        chk($sformatf("vec%0d_ready_after_abort", v), o_rdy[i], 1);
      end
    end

    // Reset dropped for two cycles in the middle of a word.
    base = commits[0];
    wait_ready(0);
    t_data[0] = 48'hF0F0_F0F0_F0F0;
    t_valid[0] = 1'b1;
    @(posedge clk); #1;
    t_valid[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_outs", {o_rdy[0], o_bz[0], o_b0[0], o_b1[0], o_cm[0], o_cnt[0]}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("midreset_ready_one_edge_after", o_rdy[0], 1);
    chk("midreset_no_commit", commits[0] - base, 0);
    send(0, 48'h0F0F_3C3C_5A5A, 0);
    chk("midreset_next_word", rx_word[0], 48'h0F0F_3C3C_5A5A);

    // i_valid held high over two words: the second handshake closes on the edge after o_ready
    // is first visible (E99), so its first strobe lands 99 cycles after the first word's.
    base = commits[0];
    wait_ready(0);
    t_data[0] = 48'hC3C3_0000_1111;
    t_valid[0] = 1'b1;
    @(posedge clk); #1;
    t_data[0] = 48'h7E7E_8181_2222;
    f0 = -1;
    for (int k = 0; k < 300 && commits[0] - base < 1; k++) begin
      @(negedge clk); #1;
    end
    f0 = first_cyc[0];
    chk("b2b_word1", rx_word[0], 48'hC3C3_0000_1111);
    for (int k = 0; k < 300 && first_cyc[0] == f0; k++) begin
      @(negedge clk); #1;
    end
    chk("b2b_second_first_strobe_spacing", first_cyc[0] - f0, 99);
    t_valid[0] = 1'b0;
    wait_ready(0);
    chk("b2b_commits", commits[0] - base, 2);
    chk("b2b_word2", rx_word[0], 48'h7E7E_8181_2222);

    // Random words, random instance, occasional abort and idle-time abort pulses.
    for (int n = 0; n < 24; n++) begin
      int i, ab;
      logic [N-1:0] d;
      i = int'($urandom_range(0, 1));
      r64 = {$urandom, $urandom};
      d = r64[N-1:0];
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N)) : 0;
      if ($urandom_range(0, 2) == 0) begin
        t_abort[i] = 1'b1;
        @(posedge clk); #1;
        t_abort[i] = 1'b0;
      end
      base = commits[i];
      send(i, d, ab);
      chk($sformatf("rand%0d_commits", n), commits[i] - base, (ab == 0) ? 1 : 0);
      if (ab == 0) chk($sformatf("rand%0d_word", n), rx_word[i], d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d: got running want finished", cyc);
    $fatal(1, "global timeout");
  end

endmodule
